expr_eval: RTL and testbench

//  - Downstream consumer of the expression character stream checked by the recognizer.
//  - Evaluates the expression while characters arrive: single ASCII digits joined by '+' or '*'.
//  - '*' binds tighter than '+'.
//  - Presents a registered running value, a legality flag and a sticky overflow flag to the next stage.

---
 rtl/expr_eval.sv | 166 ++++++++++++++++
 tb/tb_expr_eval.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - streaming evaluator for digit expressions joined by '+' and '*'
// Optional feature macro: EXPR_EVAL_SUB_EN adds '-' as a signed operator with '+' precedence.
module expr_eval #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] value,
    output logic             ok,
    output logic             err,
    output logic             ovf
);

    localparam int W2 = 2 * WIDTH;

`ifdef EXPR_EVAL_SUB_EN
    typedef enum logic [2:0] {S_EMPTY, S_NUM, S_OPADD, S_OPMUL, S_OPSUB, S_DEAD} state_t;
`else
    typedef enum logic [2:0] {S_EMPTY, S_NUM, S_OPADD, S_OPMUL, S_DEAD} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             ok_q, err_q, ovf_q, ovf_d;

    // Widen to the double-width working precision (sign-extended when '-' is enabled).
    function automatic logic [W2-1:0] ext(input logic [WIDTH-1:0] x);
`ifdef EXPR_EVAL_SUB_EN
        return {{WIDTH{x[WIDTH-1]}}, x};
`else
        return {{WIDTH{1'b0}}, x};
`endif
    endfunction

    function automatic logic fits(input logic [W2-1:0] r);
`ifdef EXPR_EVAL_SUB_EN
        return r[W2-1:WIDTH] == {WIDTH{r[WIDTH-1]}};
`else
        return r[W2-1:WIDTH] == {WIDTH{1'b0}};
`endif
    endfunction

    logic             is_digit;
    logic [WIDTH-1:0] d_w;
    logic [W2-1:0]    d_x;
    logic [W2-1:0]    add_st, add_sd, mul_td, mul_sum;
`ifdef EXPR_EVAL_SUB_EN
    logic [W2-1:0]    sub_sd;
`endif

    // ASCII '0'..'9' carry their numeric value in the low nibble.
    assign is_digit = (in >= 8'h30) && (in <= 8'h39);
    assign d_w      = {{(WIDTH-4){1'b0}}, in[3:0]};
    assign d_x      = {{(W2-4){1'b0}}, in[3:0]};
    assign add_st   = ext(sum_q) + ext(term_q);
    assign add_sd   = ext(sum_q) + d_x;
    assign mul_td   = ext(term_q) * d_x;
    assign mul_sum  = ext(sum_q) + ext(mul_td[WIDTH-1:0]);
`ifdef EXPR_EVAL_SUB_EN
    assign sub_sd   = ext(sum_q) - d_x;
`endif

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        term_d  = term_q;
        value_d = value_q;
        ovf_d   = ovf_q;
        if (in_valid) begin
            case (state_q)
                S_EMPTY: begin
                    if (is_digit) begin
                        state_d = S_NUM;
                        term_d  = d_w;
                        sum_d   = '0;
                        value_d = d_w;
                    end else begin
                        state_d = S_DEAD;
                    end
                end
                S_NUM: begin
                    if (in == 8'h2B) begin
                        state_d = S_OPADD;
                        sum_d   = add_st[WIDTH-1:0];
                        term_d  = '0;
                        ovf_d   = ovf_q | ~fits(add_st);
`ifdef EXPR_EVAL_SUB_EN
                    end else if (in == 8'h2D) begin
                        state_d = S_OPSUB;
                        sum_d   = add_st[WIDTH-1:0];
                        term_d  = '0;
                        ovf_d   = ovf_q | ~fits(add_st);
`endif
                    end else if (in == 8'h2A) begin
                        state_d = S_OPMUL;
                    end else begin
                        state_d = S_DEAD;
                    end
                end
                S_OPADD: begin
                    if (is_digit) begin
                        state_d = S_NUM;
                        term_d  = d_w;
                        value_d = add_sd[WIDTH-1:0];
                        ovf_d   = ovf_q | ~fits(add_sd);
                    end else begin
                        state_d = S_DEAD;
                    end
                end
`ifdef EXPR_EVAL_SUB_EN
                S_OPSUB: begin
                    if (is_digit) begin
                        state_d = S_NUM;
                        term_d  = '0 - d_w;
                        value_d = sub_sd[WIDTH-1:0];
                        ovf_d   = ovf_q | ~fits(sub_sd);
                    end else begin
                        state_d = S_DEAD;
                    end
                end
`endif
                S_OPMUL: begin
                    if (is_digit) begin
                        state_d = S_NUM;
                        term_d  = mul_td[WIDTH-1:0];
                        value_d = mul_sum[WIDTH-1:0];
                        ovf_d   = ovf_q | ~fits(mul_td) | ~fits(mul_sum);
                    end else begin
                        state_d = S_DEAD;
                    end
                end
                default: state_d = S_DEAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_EMPTY;
            sum_q   <= '0;
            term_q  <= '0;
            value_q <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            term_q  <= term_d;
            value_q <= value_d;
            ok_q    <= (state_d == S_NUM);
            err_q   <= (state_d == S_DEAD);
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign ok    = ok_q;
    assign err   = err_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_expr_eval.sv
// tb/tb_expr_eval.sv - scoreboard bench for expr_eval at WIDTH=16 and WIDTH=8
module tb_expr_eval;

    typedef struct {
        logic        sel8;
        int          tnum;
        int          idx;
        logic [15:0] value;
        logic        ok;
        logic        err;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  in_ch = 8'h00;
    logic        in_v = 1'b0;
    logic [15:0] v16;
    logic [7:0]  v8;
    logic        ok16, err16, ovf16, ok8, err8, ovf8;

    exp_t exp_q[$];
    int   tot_cnt = 0;
    int   pass_cnt = 0;
    logic cur_sel8 = 1'b0;
    int   cur_t = 0;
    int   cur_i = 0;

    expr_eval #(.WIDTH(16)) dut16 (
        .clk(clk), .clr(clr), .in(in_ch), .in_valid(in_v),
        .value(v16), .ok(ok16), .err(err16), .ovf(ovf16)
    );

    expr_eval #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .in(in_ch), .in_valid(in_v),
        .value(v8), .ok(ok8), .err(err8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int t, input int i,
                       input logic [15:0] act, input logic [15:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL t%0d.%0d %s: got %0h expected %0h", t, i, name, act, exp);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.sel8) begin
                chk("value8", e.tnum, e.idx, {8'h00, v8}, e.value);
                chk("ok8",    e.tnum, e.idx, {15'd0, ok8},  {15'd0, e.ok});
                chk("err8",   e.tnum, e.idx, {15'd0, err8}, {15'd0, e.err});
                chk("ovf8",   e.tnum, e.idx, {15'd0, ovf8}, {15'd0, e.ovf});
            end else begin
                chk("value16", e.tnum, e.idx, v16, e.value);
                chk("ok16",    e.tnum, e.idx, {15'd0, ok16},  {15'd0, e.ok});
                chk("err16",   e.tnum, e.idx, {15'd0, err16}, {15'd0, e.err});
                chk("ovf16",   e.tnum, e.idx, {15'd0, ovf16}, {15'd0, e.ovf});
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] ch, input logic [15:0] ev,
                        input logic eok, input logic eerr, input logic eovf);
        exp_t e;
        in_ch = ch;
        in_v  = v;
        @(posedge clk);
        e.sel8 = cur_sel8; e.tnum = cur_t; e.idx = cur_i;
        e.value = ev; e.ok = eok; e.err = eerr; e.ovf = eovf;
        exp_q.push_back(e);
        cur_i++;
        #1;
        in_v = 1'b0;
    endtask

    // Pulse clr between edges and check the asynchronous clear on both instances.
    task automatic do_clr(input int t, input logic sel8);
        @(negedge clk);
        #1;
        clr = 1'b1;
        in_v = 1'b0;
        #1;
        chk("clr_value16", t, -1, v16, 16'h0000);
        chk("clr_ok16",    t, -1, {15'd0, ok16},  16'h0000);
        chk("clr_err16",   t, -1, {15'd0, err16}, 16'h0000);
        chk("clr_ovf16",   t, -1, {15'd0, ovf16}, 16'h0000);
        chk("clr_value8",  t, -1, {8'h00, v8},    16'h0000);
        chk("clr_ok8",     t, -1, {15'd0, ok8},   16'h0000);
        #1;
        clr = 1'b0;
        cur_t = t;
        cur_i = 0;
        cur_sel8 = sel8;
    endtask

    initial begin
        #2;
        do_clr(1, 1'b0);
        step(1, "1", 16'd1, 1, 0, 0);
        step(1, "+", 16'd1, 0, 0, 0);
        step(1, "2", 16'd3, 1, 0, 0);
        step(1, "*", 16'd3, 0, 0, 0);
        step(1, "3", 16'd7, 1, 0, 0);

        do_clr(2, 1'b0);
        step(1, "2", 16'd2,  1, 0, 0);
        step(1, "*", 16'd2,  0, 0, 0);
        step(1, "3", 16'd6,  1, 0, 0);
        step(1, "*", 16'd6,  0, 0, 0);
        step(1, "4", 16'd24, 1, 0, 0);
        step(1, "+", 16'd24, 0, 0, 0);
        step(1, "5", 16'd29, 1, 0, 0);

        do_clr(3, 1'b0);
        step(1, "1", 16'd1, 1, 0, 0);
        step(1, "+", 16'd1, 0, 0, 0);
        step(1, "+", 16'd1, 0, 1, 0);
        step(1, "2", 16'd1, 0, 1, 0);

        do_clr(4, 1'b1);
        step(1, "9", 16'd9,   1, 0, 0);
        step(1, "*", 16'd9,   0, 0, 0);
        step(1, "9", 16'd81,  1, 0, 0);
        step(1, "*", 16'd81,  0, 0, 0);
        step(1, "9", 16'd217, 1, 0, 1);
        step(1, "+", 16'd217, 0, 0, 1);
        step(1, "1", 16'd218, 1, 0, 1);

        do_clr(5, 1'b0);
        step(1, "3", 16'd3, 1, 0, 0);
        step(1, "*", 16'd3, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, "7", 16'd3, 0, 0, 0);
        do_clr(5, 1'b0);
        step(1, "4", 16'd4, 1, 0, 0);

        do_clr(6, 1'b0);
`ifdef EXPR_EVAL_SUB_EN
        step(1, "2", 16'd2,    1, 0, 0);
        step(1, "-", 16'd2,    0, 0, 0);
        step(1, "3", 16'hFFFF, 1, 0, 0);
        step(1, "*", 16'hFFFF, 0, 0, 0);
        step(1, "4", 16'hFFF6, 1, 0, 0);
`else
        step(1, "2", 16'd2, 1, 0, 0);
        step(1, "-", 16'd2, 0, 1, 0);
        step(1, "3", 16'd2, 0, 1, 0);
        step(1, "*", 16'd2, 0, 1, 0);
        step(1, "4", 16'd2, 0, 1, 0);
`endif

        do_clr(7, 1'b0);
        step(1, "5", 16'd5, 1, 0, 0);
        step(1, "*", 16'd5, 0, 0, 0);
        step(1, "0", 16'd0, 1, 0, 0);
        step(1, "*", 16'd0, 0, 0, 0);
        step(1, "7", 16'd0, 1, 0, 0);
        step(1, "+", 16'd0, 0, 0, 0);
        step(1, "1", 16'd1, 1, 0, 0);

        do_clr(8, 1'b0);
        step(1, "x", 16'd0, 0, 1, 0);
        step(1, "1", 16'd0, 0, 1, 0);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #2;
        tot_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
